// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: owns all pipeline-register enables and flushes.
// Optional watchdog abort on long waits is enabled with `define PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_address,
    input  logic [4:0]       id_rs2_address,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_address,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_valid,
    input  logic             muldiv_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             wdog_err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MULDIV = 2'b01,
        ST_MEM    = 2'b10
    } state_t;

    state_t state, state_next;

    logic mem_stall;
    logic md_stall;
    logic load_use;
    logic use_run;
    logic md_check;
    logic wdog_fire;

    assign mem_stall = mem_req && !mem_ready;
    assign md_stall  = ex_muldiv_valid && !muldiv_done;
    assign load_use  = ex_mem_read && (ex_rd_address != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                        (id_uses_rs2 && (id_rs2_address == ex_rd_address)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_next   = state;
        use_run      = 1'b0;
        md_check     = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                    state_next = ST_MEM;
                end else begin
                    use_run  = 1'b1;
                    md_check = 1'b1;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                end else begin
                    use_run    = 1'b1;
                    md_check   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_MULDIV: begin
                if (mem_stall) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                    state_next = ST_MEM;
                end else if (!muldiv_done) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                end else begin
                    use_run    = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                state_next = ST_RUN;
            end
        endcase

        // Shared RUN decode; a pending mul/div released from MEM is re-detected next cycle in RUN.
        if (use_run) begin
            if (md_check && md_stall) begin
                {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                if (state == ST_RUN) begin
                    state_next = ST_MULDIV;
                end
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (wdog_fire) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = ST_RUN;
        end

        if (!rst_n) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign ctrl_state = state;

`ifdef PIPE_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wdog_cnt;

    // Fires on the WDOG_LIMIT-th consecutive cycle spent outside RUN.
    assign wdog_fire = (state != ST_RUN) && (wdog_cnt == WD_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if ((state == ST_RUN) || wdog_fire) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end
            if (wdog_fire) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^WDOG_LIMIT;
    assign wdog_fire       = 1'b0;
    assign wdog_err        = 1'b0;
`endif

endmodule
